// File: rtl/kyber_ct_feeder.sv
// Ciphertext source for the Kyber decapsulation wrapper: host fills a word buffer, arms it,
// and the wrapper pulls words by index. Optional post-stream buffer wipe: KYBER_FEEDER_WIPE_EN.
module kyber_ct_feeder #(
    parameter int CT_WORDS = 192,
    parameter int AW       = 8,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_go,
    input  logic          host_abort,
    input  logic [AW-1:0] k_addr,
    output logic          load_o,
    output logic [DW-1:0] din,
    output logic          ready,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {IDLE, FILL, LOAD, STREAM, WIPE} state_t;

    localparam logic [AW-1:0] CT_N = AW'(CT_WORDS);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] cnt_post;
    logic          err_q, err_d;
    logic          wr_ok;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [DW-1:0] buf_wdata;
    logic [DW-1:0] buf_q [CT_WORDS];
`ifdef KYBER_FEEDER_WIPE_EN
    logic [AW-1:0] wipe_cnt_q, wipe_cnt_d;
`else
    logic          done_q, done_d;
`endif

    assign wr_ok = host_we && (host_addr < CT_N);

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        err_d     = err_q;
        buf_we    = 1'b0;
        buf_waddr = host_addr;
        buf_wdata = host_wdata;
        cnt_post  = wr_cnt_q;
`ifdef KYBER_FEEDER_WIPE_EN
        wipe_cnt_d = wipe_cnt_q;
`else
        done_d     = 1'b0;
`endif
        case (state_q)
            IDLE, FILL: begin
                if (host_we) begin
                    if (state_q == IDLE) err_d = 1'b0;
                    if (wr_ok) begin
                        buf_we   = 1'b1;
                        cnt_post = (wr_cnt_q == CT_N) ? CT_N : wr_cnt_q + 1'b1;
                        state_d  = FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                wr_cnt_d = cnt_post;
                // The go check sees this cycle's write already counted
                if (host_go) begin
                    if (cnt_post == CT_N) state_d = LOAD;
                    else                  err_d   = 1'b1;
                end
            end
            LOAD: begin
                if (host_we) err_d = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (host_we) err_d = 1'b1;
                if (k_addr == CT_N) begin
`ifdef KYBER_FEEDER_WIPE_EN
                    state_d    = WIPE;
                    wipe_cnt_d = '0;
`else
                    state_d    = IDLE;
                    done_d     = 1'b1;
`endif
                end
            end
`ifdef KYBER_FEEDER_WIPE_EN
            WIPE: begin
                if (host_we) err_d = 1'b1;
                buf_we     = 1'b1;
                buf_waddr  = wipe_cnt_q;
                buf_wdata  = '0;
                wipe_cnt_d = wipe_cnt_q + 1'b1;
                if (wipe_cnt_q == CT_N - 1'b1) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Abort wins over everything but reset; a wipe in progress always completes
        if (host_abort && (state_q != WIPE)) begin
            state_d = IDLE;
            buf_we  = 1'b0;
`ifndef KYBER_FEEDER_WIPE_EN
            done_d  = 1'b0;
`endif
        end

        if (state_d == IDLE) wr_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_cnt_q   <= '0;
            err_q      <= 1'b0;
`ifdef KYBER_FEEDER_WIPE_EN
            wipe_cnt_q <= '0;
`else
            done_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
`ifdef KYBER_FEEDER_WIPE_EN
            wipe_cnt_q <= wipe_cnt_d;
`else
            done_q     <= done_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[buf_waddr] <= buf_wdata;
    end

    // Buffer is only visible while streaming, so ciphertext never sits on the bus
    assign din    = ((state_q == STREAM) && (k_addr < CT_N)) ? buf_q[k_addr] : '0;
    assign load_o = (state_q == LOAD);
    assign ready  = (state_q == IDLE) || (state_q == FILL);
    assign err    = err_q;
`ifdef KYBER_FEEDER_WIPE_EN
    assign done   = (state_q == WIPE) && (wipe_cnt_q == CT_N - 1'b1);
`else
    assign done   = done_q;
`endif

endmodule

// File: tb/tb_kyber_ct_feeder.sv
// Directed bench for kyber_ct_feeder: fill/arm/stream, short fill, bad addresses, abort, reset.
module tb_kyber_ct_feeder;
    logic        clk = 1'b0;
    logic        rst, host_we, host_go, host_abort;
    logic [7:0]  host_addr, k_addr;
    logic [31:0] host_wdata;
    logic        load_o, ready, done, err;
    logic [31:0] din;
    int          tests = 0;
    int          fails = 0;

    kyber_ct_feeder #(.CT_WORDS(192), .AW(8), .DW(32)) dut (
        .clk(clk), .rst(rst), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_go(host_go), .host_abort(host_abort),
        .k_addr(k_addr), .load_o(load_o), .din(din), .ready(ready),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_range(input int lo, input int hi, input logic [31:0] base);
        for (int i = lo; i <= hi; i++) begin
            host_we    = 1'b1;
            host_addr  = 8'(i);
            host_wdata = base + 32'(i);
            tick();
        end
        host_we = 1'b0;
    endtask

    task automatic arm();
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; host_we = 1'b0; host_go = 1'b0; host_abort = 1'b0;
        host_addr = '0; host_wdata = '0; k_addr = '0;
        tick(); tick();
        rst = 1'b0;
        tests++; if (ready !== 1'b1)  begin fails++; $display("FAIL reset_ready: got %b expected 1", ready); end
        tests++; if (done !== 1'b0)   begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (err !== 1'b0)    begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        tests++; if (load_o !== 1'b0) begin fails++; $display("FAIL reset_load: got %b expected 0", load_o); end
        tests++; if (din !== 32'h0)   begin fails++; $display("FAIL reset_din: got %h expected 0", din); end
    endtask

    task automatic test_stream();
        fill_range(0, 191, 32'hC0DE0000);
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        tests++; if (load_o !== 1'b1) begin fails++; $display("FAIL stream_load: got %b expected 1", load_o); end
        tests++; if (ready !== 1'b0)  begin fails++; $display("FAIL stream_ready_load: got %b expected 0", ready); end
        tests++; if (din !== 32'h0)   begin fails++; $display("FAIL stream_din_load: got %h expected 0", din); end
        tick();
        tests++; if (load_o !== 1'b0) begin fails++; $display("FAIL stream_load_once: got %b expected 0", load_o); end
        for (int k = 0; k < 192; k++) begin
            k_addr = 8'(k);
            #1;
            tests++;
            if (din !== 32'hC0DE0000 + 32'(k) || load_o !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL stream_word[%0d]: got din=%h load=%b done=%b expected din=%h load=0 done=0",
                         k, din, load_o, done, 32'hC0DE0000 + 32'(k));
            end
            tick();
        end
        k_addr = 8'd192;
        tick();
        tests++; if (done !== 1'b1)  begin fails++; $display("FAIL stream_done: got %b expected 1", done); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL stream_ready_end: got %b expected 1", ready); end
        tests++; if (din !== 32'h0)  begin fails++; $display("FAIL stream_din_idle: got %h expected 0", din); end
        tick();
        tests++; if (done !== 1'b0)  begin fails++; $display("FAIL stream_done_pulse: got %b expected 0", done); end
        tests++; if (err !== 1'b0)   begin fails++; $display("FAIL stream_err: got %b expected 0", err); end
    endtask

    task automatic test_short_fill();
        k_addr = 8'd0;
        fill_range(0, 190, 32'hA5000000);
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        tests++; if (err !== 1'b1)    begin fails++; $display("FAIL short_err: got %b expected 1", err); end
        tests++; if (ready !== 1'b1)  begin fails++; $display("FAIL short_ready: got %b expected 1", ready); end
        tests++; if (load_o !== 1'b0) begin fails++; $display("FAIL short_load: got %b expected 0", load_o); end
        fill_range(191, 191, 32'hA5000000);
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        tests++; if (load_o !== 1'b1) begin fails++; $display("FAIL short_full_load: got %b expected 1", load_o); end
        tick();
        k_addr = 8'd0;   #1;
        tests++; if (din !== 32'hA5000000) begin fails++; $display("FAIL short_w0: got %h expected a5000000", din); end
        k_addr = 8'd191; #1;
        tests++; if (din !== 32'hA50000BF) begin fails++; $display("FAIL short_w191: got %h expected a50000bf", din); end
        k_addr = 8'd200; #1;
        tests++; if (din !== 32'h0) begin fails++; $display("FAIL short_oor_din: got %h expected 0", din); end
        tick();
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL short_oor_stay: got ready=%b expected 0", ready); end
        k_addr = 8'd192;
        tick();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL short_done: got %b expected 1", done); end
        k_addr = 8'd0;
        tick();
    endtask

    // Bad addresses, then the last word written together with go
    task automatic test_bad_addr_and_same_cycle();
        host_we = 1'b1; host_addr = 8'd200; host_wdata = 32'hBAD0BAD0;
        tick();
        host_we = 1'b0;
        tests++; if (err !== 1'b1)   begin fails++; $display("FAIL badaddr_err: got %b expected 1", err); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL badaddr_ready: got %b expected 1", ready); end
        host_we = 1'b1; host_addr = 8'd0; host_wdata = 32'h3C000000;
        tick();
        host_we = 1'b0;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL idle_write_clears_err: got %b expected 0", err); end
        host_we = 1'b1; host_addr = 8'd192; host_wdata = 32'hBAD0BAD0;
        tick();
        host_we = 1'b0;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL fill_addr192_err: got %b expected 1", err); end
        // Word 8 is skipped (9 written twice) so it must keep its previous value
        for (int i = 1; i <= 190; i++) begin
            host_we    = 1'b1;
            host_addr  = (i == 8) ? 8'd9 : 8'(i);
            host_wdata = 32'h3C000000 + 32'(host_addr);
            tick();
        end
        host_we = 1'b0;
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        tests++; if (load_o !== 1'b0) begin fails++; $display("FAIL bad_write_not_counted: got load=%b expected 0", load_o); end
        host_we = 1'b1; host_addr = 8'd191; host_wdata = 32'h3C0000BF; host_go = 1'b1;
        tick();
        host_we = 1'b0; host_go = 1'b0;
        tests++; if (load_o !== 1'b1) begin fails++; $display("FAIL same_cycle_load: got %b expected 1", load_o); end
        tick();
        k_addr = 8'd8;   #1;
        tests++; if (din !== 32'hA5000008) begin fails++; $display("FAIL buf_unchanged_w8: got %h expected a5000008", din); end
        k_addr = 8'd9;   #1;
        tests++; if (din !== 32'h3C000009) begin fails++; $display("FAIL rewrite_w9: got %h expected 3c000009", din); end
        k_addr = 8'd191; #1;
        tests++; if (din !== 32'h3C0000BF) begin fails++; $display("FAIL same_cycle_w191: got %h expected 3c0000bf", din); end
        k_addr = 8'd192;
        tick();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL bad_done: got %b expected 1", done); end
        k_addr = 8'd0;
        tick();
    endtask

    task automatic test_abort();
        fill_range(0, 191, 32'h5A000000);
        arm();
        for (int k = 0; k < 50; k++) begin
            k_addr = 8'(k);
            tick();
        end
        k_addr = 8'd50; #1;
        tests++; if (din !== 32'h5A000032) begin fails++; $display("FAIL abort_w50: got %h expected 5a000032", din); end
        host_abort = 1'b1;
        tick();
        host_abort = 1'b0;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b expected 1", ready); end
        tests++; if (din !== 32'h0)  begin fails++; $display("FAIL abort_din: got %h expected 0", din); end
        tests++; if (done !== 1'b0)  begin fails++; $display("FAIL abort_done: got %b expected 0", done); end
        k_addr = 8'd192;
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_no_done: got %b expected 0", done); end
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        tick();
        tests++; if (ready !== 1'b1 || err !== 1'b1) begin
            fails++; $display("FAIL abort_refill_needed: got ready=%b err=%b expected ready=1 err=1", ready, err);
        end
        k_addr = 8'd0;
    endtask

    task automatic test_reset_mid_stream();
        fill_range(0, 191, 32'h77000000);
        arm();
        k_addr = 8'd3; #1;
        tests++; if (din !== 32'h77000003) begin fails++; $display("FAIL mid_w3: got %h expected 77000003", din); end
        host_we = 1'b1; host_addr = 8'd4; host_wdata = 32'hDEADBEEF;
        tick();
        host_we = 1'b0;
        k_addr = 8'd4; #1;
        tests++; if (err !== 1'b1 || din !== 32'h77000004) begin
            fail_print_stream_we();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (ready !== 1'b1 || din !== 32'h0 || err !== 1'b0 || load_o !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got ready=%b din=%h err=%b load=%b done=%b expected 1 0 0 0 0",
                     ready, din, err, load_o, done);
        end
    endtask

    task automatic fail_print_stream_we();
        fails++;
        $display("FAIL stream_write_dropped: got err=%b din=%h expected err=1 din=77000004", err, din);
    endtask

`ifdef KYBER_FEEDER_WIPE_EN
    task automatic test_wipe();
        int n = 0;
        bit got = 0;
        int nz = 0;
        fill_range(0, 191, 32'h99000000);
        arm();
        k_addr = 8'd192;
        while (n < 400 && !got) begin
            tick();
            n++;
            if (done) got = 1;
        end
        tests++; if (!got || n != 192) begin fails++; $display("FAIL wipe_done_delay: got %0d cycles expected 192", n); end
        tick();
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
        tests++; if (err !== 1'b1 || load_o !== 1'b0) begin
            fails++; $display("FAIL wipe_no_restream: got err=%b load=%b expected err=1 load=0", err, load_o);
        end
        for (int i = 0; i < 192; i++) if (dut.buf_q[i] !== 32'h0) nz++;
        tests++; if (nz != 0) begin fails++; $display("FAIL wipe_buffer: got %0d nonzero words expected 0", nz); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef KYBER_FEEDER_WIPE_EN
        test_wipe();
`else
        test_stream();
        test_short_fill();
        test_bad_addr_and_same_cycle();
        test_abort();
        test_reset_mid_stream();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
